// File: rtl/skinny_sbox_layer_ctrl_cms1.sv
// ---------------------------------------------------------------------------
// skinny_sbox_layer_ctrl_cms1
//
// Purpose:
//   Drives one shared, externally instantiated 2-share CMS1 SKINNY sbox8
//   (non-pipelined, SBOX_LAT register stages) across every byte of a
//   two-share state, byte 0 first and byte NBYTES-1 last. Each byte's shares
//   are held on the sbox inputs until SBOX_LAT consecutive cycles of fresh
//   randomness have been fed to the sbox. The sbox result is then written back
//   into the same byte position. The two shares are only ever muxed and
//   registered separately and are never combined inside this block.
//
// Optional feature:
//   CMS1_SBOX_FLUSH_EN - when defined, a one-cycle FLUSH state drives zero on
//   both sbox share inputs between consecutive bytes. This removes direct
//   share-to-share transitions on the sbox inputs. No FLUSH follows the
//   last byte.
//
// Ports:
//   clk, rst_n             clock (rising edge) and asynchronous active-low reset
//   start_i                begin a layer run; honoured only in IDLE or DONE
//   state0_i, state1_i     input state shares, captured on the start edge
//   rnd_i, rnd_valid_i     fresh randomness and its valid flag
//   rnd_ready_o            randomness consumed this cycle (high only in FEED)
//   sb_si0_o, sb_si1_o     sbox input shares
//   sb_r_o                 sbox refresh mask (rnd_i in FEED, otherwise zero)
//   sb_bo0_i, sb_bo1_i     sbox output shares
//   busy_o                 layer in progress
//   done_o                 one-cycle pulse when state0_o/state1_o are final
//   state0_o, state1_o     result shares, held until the next start
// ---------------------------------------------------------------------------
module skinny_sbox_layer_ctrl_cms1 #(
    parameter int NBYTES   = 16,
    parameter int SBOX_LAT = 4,
    parameter int RW       = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_i,
    input  logic [8*NBYTES-1:0] state0_i,
    input  logic [8*NBYTES-1:0] state1_i,
    input  logic [RW-1:0]       rnd_i,
    input  logic                rnd_valid_i,
    output logic                rnd_ready_o,
    output logic [7:0]          sb_si0_o,
    output logic [7:0]          sb_si1_o,
    output logic [RW-1:0]       sb_r_o,
    input  logic [7:0]          sb_bo0_i,
    input  logic [7:0]          sb_bo1_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [8*NBYTES-1:0] state0_o,
    output logic [8*NBYTES-1:0] state1_o
);

    localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int CNT_W = $clog2(SBOX_LAT + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SBOX_LAT - 1);

`ifdef CMS1_SBOX_FLUSH_EN
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FEED  = 3'd1,
        CAPT  = 3'd2,
        FLUSH = 3'd3,
        DONE  = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FEED  = 3'd1,
        CAPT  = 3'd2,
        DONE  = 3'd4
    } state_t;
`endif

    state_t              st;
    state_t              stNext;
    logic [IDX_W-1:0]    idx;
    logic [IDX_W-1:0]    idxNext;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cntNext;
    logic [8*NBYTES-1:0] s0;
    logic [8*NBYTES-1:0] s1;
    logic                load;
    logic                capture;
    logic [7:0]          curByte0;
    logic [7:0]          curByte1;

    // Share-wise selection of the byte currently being substituted.
    assign curByte0 = s0[{idx, 3'b000} +: 8];
    assign curByte1 = s1[{idx, 3'b000} +: 8];

    assign state0_o = s0;
    assign state1_o = s1;

    // State register, byte index, settle counter and the two share registers.
    // The share registers change only when a run is loaded or when a byte is
    // captured from the sbox.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st  <= IDLE;
            idx <= '0;
            cnt <= '0;
            s0  <= '0;
            s1  <= '0;
        end else begin
            st  <= stNext;
            idx <= idxNext;
            cnt <= cntNext;
            if (load) begin
                s0 <= state0_i;
                s1 <= state1_i;
            end else if (capture) begin
                s0[{idx, 3'b000} +: 8] <= sb_bo0_i;
                s1[{idx, 3'b000} +: 8] <= sb_bo1_i;
            end
        end
    end

    // Next-state and output decode. A missing randomness word clears the
    // settle counter, so every byte sees SBOX_LAT consecutive fresh refresh
    // words and no refresh value is reused across a stall.
    always_comb begin
        stNext      = st;
        idxNext     = idx;
        cntNext     = cnt;
        load        = 1'b0;
        capture     = 1'b0;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        rnd_ready_o = 1'b0;
        sb_r_o      = '0;
        sb_si0_o    = '0;
        sb_si1_o    = '0;

        case (st)
            IDLE: begin
                if (start_i) begin
                    load    = 1'b1;
                    idxNext = '0;
                    cntNext = '0;
                    stNext  = FEED;
                end
            end

            FEED: begin
                busy_o      = 1'b1;
                sb_si0_o    = curByte0;
                sb_si1_o    = curByte1;
                sb_r_o      = rnd_i;
                rnd_ready_o = 1'b1;
                if (rnd_valid_i) begin
                    cntNext = cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        stNext = CAPT;
                    end
                end else begin
                    cntNext = '0;
                end
            end

            CAPT: begin
                busy_o   = 1'b1;
                sb_si0_o = curByte0;
                sb_si1_o = curByte1;
                capture  = 1'b1;
                cntNext  = '0;
                if (idx == LAST_IDX) begin
                    stNext = DONE;
                end else begin
                    idxNext = idx + 1'b1;
`ifdef CMS1_SBOX_FLUSH_EN
                    stNext  = FLUSH;
`else
                    stNext  = FEED;
`endif
                end
            end

`ifdef CMS1_SBOX_FLUSH_EN
            FLUSH: begin
                busy_o = 1'b1;
                stNext = FEED;
            end
`endif

            DONE: begin
                done_o = 1'b1;
                if (start_i) begin
                    load    = 1'b1;
                    idxNext = '0;
                    cntNext = '0;
                    stNext  = FEED;
                end else begin
                    stNext = IDLE;
                end
            end

            default: begin
                stNext = IDLE;
            end
        endcase
    end

endmodule
